// File: rtl/acacia_arb_pkg.sv
// Shared types and helpers for the acacia grant arbiter.
// State encoding and index-width helper used by the arbiter and picker.
package acacia_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  // Width needed to hold an index 0..n-1 (at least one bit).
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acacia_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request searching upward from last+1 with wrap.
module acacia_rr_pick
  import acacia_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    idx
);

  int          w_pos;
  logic [IW-1:0] w_cand;

  // Scan N_REQ candidates starting just after the previous winner.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_pos  = 0;
    w_cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos  = (int'(last) + k) % N_REQ;
      w_cand = IW'(w_pos);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/acacia_grant_arbiter.sv
// Round-robin req/go/cancel grant arbiter with registered outputs.
// Optional ownership time limit: define ACACIA_ARB_MAX_HOLD_EN.
module acacia_grant_arbiter
  import acacia_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int OFFER_TIMEOUT = 8,
  parameter int MAX_HOLD      = 16,
  localparam int IW = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] go,
  input  logic [N_REQ-1:0] cancel,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id,
`ifdef ACACIA_ARB_MAX_HOLD_EN
  output logic             hold_expired,
`endif
  output logic             busy
);

  localparam int OW = id_w(OFFER_TIMEOUT);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n
    $error("N_REQ out of range");
  end
  if (OFFER_TIMEOUT < 1) begin : g_bad_to
    $error("OFFER_TIMEOUT must be >= 1");
  end
  if (MAX_HOLD < 1) begin : g_bad_mh
    $error("MAX_HOLD must be >= 1");
  end

  arb_state_e       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IW-1:0]    r_gid;
  logic [IW-1:0]    r_last;
  logic             r_busy;
  logic [OW-1:0]    r_ocnt;

`ifdef ACACIA_ARB_MAX_HOLD_EN
  localparam int HW = id_w(MAX_HOLD);
  logic [HW-1:0]    r_hcnt;
  logic             r_hexp;
`endif

  logic             w_found;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_onehot;
  logic             w_win_go;
  logic             w_release;

  acacia_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req),
    .last (r_last),
    .found(w_found),
    .idx  (w_idx)
  );

  // Only the current winner's go/cancel/req bits matter.
  assign w_onehot  = N_REQ'(1) << w_idx;
  assign w_win_go  = go[r_gid];
  assign w_release = cancel[r_gid] | ~req[r_gid];

  // Arbiter FSM, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gid   <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_busy  <= 1'b0;
      r_ocnt  <= '0;
`ifdef ACACIA_ARB_MAX_HOLD_EN
      r_hcnt  <= '0;
      r_hexp  <= 1'b0;
`endif
    end else begin
`ifdef ACACIA_ARB_MAX_HOLD_EN
      r_hexp <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          if (w_found) begin
            r_grant <= w_onehot;
            r_gid   <= w_idx;
            r_last  <= w_idx;
            r_ocnt  <= '0;
            r_state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (w_release) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (w_win_go) begin
            r_busy  <= 1'b1;
`ifdef ACACIA_ARB_MAX_HOLD_EN
            r_hcnt  <= '0;
`endif
            r_state <= ST_BUSY;
          end else if (r_ocnt == OW'(OFFER_TIMEOUT - 1)) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_ocnt <= r_ocnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`ifdef ACACIA_ARB_MAX_HOLD_EN
          end else if (r_hcnt == HW'(MAX_HOLD - 1)) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_hexp  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
`endif
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_gid;
  assign busy     = r_busy;
`ifdef ACACIA_ARB_MAX_HOLD_EN
  assign hold_expired = r_hexp;
`endif

endmodule

// File: tb/tb_acacia_grant_arbiter.sv
// Bench for acacia_grant_arbiter: directed steps plus random traffic.
// Outputs are compared to an ownership model after every clock edge.
module tb_acacia_grant_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, go, cancel;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
`ifdef ACACIA_ARB_MAX_HOLD_EN
  logic       hold_expired;
`endif

  acacia_grant_arbiter #(
    .N_REQ(N), .OFFER_TIMEOUT(TO), .MAX_HOLD(MH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .go      (go),
    .cancel  (cancel),
    .grant   (grant),
    .grant_id(grant_id),
`ifdef ACACIA_ARB_MAX_HOLD_EN
    .hold_expired(hold_expired),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  int m_owner, m_last, m_gid, m_age, m_hold;
  bit m_busy, m_exp;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_gid   = 0;
    m_age   = 0;
    m_hold  = 0;
    m_busy  = 0;
    m_exp   = 0;
  endtask

  task automatic model_drop();
    m_owner = -1;
    m_busy  = 0;
  endtask

  // Ownership rules applied to the inputs seen at this clock edge.
  task automatic model_step();
    int c;
    m_exp = 0;
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_last  = c;
          m_gid   = c;
          m_age   = 0;
          m_busy  = 0;
        end
      end
    end else if (cancel[m_owner] || !req[m_owner]) begin
      model_drop();
    end else if (!m_busy) begin
      if (go[m_owner]) begin
        m_busy = 1;
        m_hold = 0;
      end else if (m_age == TO - 1) begin
        model_drop();
      end else begin
        m_age++;
      end
    end else begin
`ifdef ACACIA_ARB_MAX_HOLD_EN
      if (m_hold == MH - 1) begin
        model_drop();
        m_exp = 1;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_gid));
`ifdef ACACIA_ARB_MAX_HOLD_EN
    chk("hold_expired", 32'(hold_expired), 32'(m_exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    go     = '0;
    cancel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(int max);
    int n;
    n = 0;
    while (grant == 4'd0 && n < max) begin
      tick();
      n++;
    end
    chk("wait_grant", 32'(grant != 4'd0), 32'd1);
  endtask

  initial begin
    int n, bcnt, xcnt;
    rst_n = 1'b1;
    req = '0; go = '0; cancel = '0;
    #2;
    do_reset();

    // Single requester: grant, go, busy, cancel.
    req = 4'b0001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    tick();
    tick();
    go = 4'b0001;
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    go = '0;
    cancel = 4'b0001;
    tick();
    chk("t1_rel_grant", 32'(grant), 32'd0);
    chk("t1_rel_busy", 32'(busy), 32'd0);
    cancel = '0;
    req = '0;
    tick();

    // All requesting: 0,1,2,3,0 with a gap between owners.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(4);
      chk("t2_id", 32'(grant_id), 32'(k % 4));
      go = 4'(1 << (k % 4));
      tick();
      go = '0;
      cancel = 4'(1 << (k % 4));
      tick();
      chk("t2_gap", 32'(grant), 32'd0);
      cancel = '0;
    end
    req = '0;
    tick();

    // Offer timeout on requester 1, then re-grant after one idle cycle.
    req = 4'b0010;
    tick();
    n = 0;
    while (grant[1] && n < 20) begin
      n++;
      tick();
    end
    chk("t3_offer_len", 32'(n), 32'd8);
    chk("t3_idle", 32'(grant), 32'd0);
    tick();
    chk("t3_regrant", 32'(grant), 32'h2);
    req = '0;
    tick();

    // Go and cancel together, then non-winner go/cancel.
    req = 4'b0100;
    tick();
    chk("t4_grant", 32'(grant), 32'h4);
    go = 4'b0100;
    cancel = 4'b0100;
    tick();
    chk("t4_cancel_wins", 32'(grant), 32'd0);
    chk("t4_no_busy", 32'(busy), 32'd0);
    go = 4'b0001;
    cancel = 4'b1000;
    tick();
    tick();
    tick();
    chk("t4_nonwin_grant", 32'(grant), 32'h4);
    chk("t4_nonwin_busy", 32'(busy), 32'd0);
    go = 4'b0100;
    tick();
    chk("t4_busy", 32'(busy), 32'd1);
    go = '0;
    cancel = 4'b0001;
    bcnt = 0;
    xcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) bcnt++;
`ifdef ACACIA_ARB_MAX_HOLD_EN
      if (hold_expired) xcnt++;
`endif
    end
`ifdef ACACIA_ARB_MAX_HOLD_EN
    chk("t4_hold_cycles", 32'(bcnt), 32'(MH - 1));
    chk("t4_expire_pulses", 32'(xcnt), 32'd1);
`else
    chk("t4_hold_cycles", 32'(bcnt), 32'd30);
    chk("t4_held", 32'(busy), 32'd1);
`endif
    cancel = '0;

    // Asynchronous reset while busy.
    wait_grant(20);
    go = 4'b0100;
    tick();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    model_reset();
    go = '0;
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_first", 32'(grant), 32'h1);
    chk("t5_first_id", 32'(grant_id), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      go = 4'($urandom & $urandom);
      cancel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/acacia_grant_arbiter.md
Name: acacia_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among N_REQ requesters using the req/go/cancel/grant handshake.
- Per requester, the sequence is: request, get offered the grant, confirm with go, hold, then release with cancel or by dropping req.
- Sits in front of the shared resource; the resource-side logic sees only grant_id and busy.
- Guarantees at least one grant-free cycle between successive owners.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- OFFER_TIMEOUT, 8, cycles a grant is offered without go before it is withdrawn; must be >= 1.
- MAX_HOLD, 16, maximum BUSY cycles per ownership; used only with MAX_HOLD_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- go  in  N_REQ  per-requester confirm; sampled only from the current winner.
- cancel  in  N_REQ  per-requester release/abort; sampled only from the current winner.
- grant  out  N_REQ  one-hot or zero, registered.
- grant_id  out  $clog2(N_REQ)  index of the current winner; valid when grant is nonzero.
- busy  out  1  resource confirmed in use (state BUSY).

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, grant=0, grant_id=0, busy=0, offer/hold counters=0, last_winner=N_REQ-1 (so requester 0 has first priority).
- Outputs are all registered; no combinational paths from inputs to outputs.
- IDLE:
  - grant=0.
  - If req is nonzero at edge k, pick the first set req bit, searching upward from last_winner+1 with wrap.
  - At edge k: grant[w]=1, grant_id=w, last_winner=w, state->OFFER, offer_cnt=0.
  - Request-to-grant latency is therefore 1 cycle.
- OFFER (grant[w]=1, busy=0). Checks in priority order:
  - cancel[w] or !req[w]: ->IDLE, grant=0.
  - go[w]: ->BUSY, busy=1, hold_cnt=0.
  - offer_cnt==OFFER_TIMEOUT-1: ->IDLE, grant=0 (timed out).
  - Otherwise offer_cnt++.
  - Cancel wins over go in the same cycle.
- BUSY (grant[w]=1, busy=1):
  - cancel[w] or !req[w]: ->IDLE, grant=0, busy=0.
  - go[w] is ignored in this state.
- Signals from non-winners:
  - go/cancel from non-winners are ignored in every state.
  - A non-winner asserting req never preempts the current owner.
- Fairness:
  - Every exit to IDLE leaves last_winner at w. The next pick therefore starts at w+1, so a requester that re-requests immediately has lowest priority.
  - The IDLE cycle after any exit is mandatory: grant=0 for at least 1 cycle between owners.
- Boundary cases:
  - Single requester holding req high continuously: alternates grant/no-grant each ownership, with one IDLE cycle between ownerships.
  - All requesters active: served w+1, w+2, ... with wrap at N_REQ-1 -> 0.
  - rst_n asserted mid-OFFER or mid-BUSY: outputs clear immediately (asynchronously) and last_winner resets.
- Arithmetic: counters are sized to hold OFFER_TIMEOUT-1 and MAX_HOLD-1 and never wrap, because state exits at the terminal count.

Optional Feature:
- Macro: ACACIA_ARB_MAX_HOLD_EN.
- Defined:
  - hold_cnt increments in BUSY.
  - When hold_cnt==MAX_HOLD-1 without a release, the arbiter forces ->IDLE, grant=0, busy=0, and pulses an extra output port hold_expired (1 bit, registered, 1 cycle).
  - Normal release takes priority over expiry in the same cycle.
- Undefined:
  - No hold counter and no hold_expired port.
  - Ownership lasts until cancel or req drop.

Decomposition:
- Package acacia_arb_pkg:
  - state enum {IDLE, OFFER, BUSY}, 2-bit encoding.
  - Function id_w(n) returning $clog2 width.
- Sub-module acacia_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_winner.
  - Outputs: found, idx.
  - Parameterized by N_REQ; reusable by other arbiters.
- Top-level holds the FSM, counters and output registers.

Test Plan:
- Reset then req=4'b0001, go[0] asserted 2 cycles after grant -> grant=0001 one cycle after req; busy=1 the cycle after go; cancel[0] -> grant=0 and busy=0 next cycle.
- req=4'b1111 held, every winner replies go then cancel -> grant_id sequence 0,1,2,3,0, with a grant=0 cycle between each.
- req=4'b0010, no go -> grant[1] held exactly OFFER_TIMEOUT=8 cycles, then IDLE; next grant goes to 1 again only after 1 idle cycle.
- In OFFER, assert go[w] and cancel[w] in the same cycle -> state IDLE, busy never 1; also go/cancel on a non-winner bit -> no effect.
- In BUSY, assert rst_n=0 asynchronously between edges -> grant=0 and busy=0 immediately; after release, req=1111 is granted to requester 0 first.
- With ACACIA_ARB_MAX_HOLD_EN, winner holds in BUSY -> forced release after MAX_HOLD=16 cycles with a 1-cycle hold_expired pulse; without the macro, held indefinitely.
